// File: rtl/mfp_uart_word_loader_if.sv
// Write-request channel between the UART word loader and the downstream bus master.
// The loader holds wr_addr/wr_data stable while wr_valid is high; a transfer happens on wr_valid & wr_ready.
interface mfp_uart_word_loader_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/mfp_uart_word_loader.sv
// UART 8N1 program loader: packs four received bytes little-endian into a 32-bit word and
// offers it as a write request at an auto-incrementing address.
module mfp_uart_word_loader #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_BITS = 16
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic                           UART_RX,
    input  logic                           enable,
    mfp_uart_word_loader_if.master         bus,
    output logic                           byte_err,
    output logic                           overrun,
    output logic                           busy
);

    localparam int unsigned DIVISOR = CLK_FREQ / BAUD;
    localparam int unsigned TMO_CYC = TIMEOUT_BITS * DIVISOR;
    localparam int          TW      = $clog2(DIVISOR + 1);
    localparam int          IW      = $clog2(TMO_CYC + 1);

    localparam logic [TW-1:0] T_FULL = TW'(DIVISOR - 1);
    localparam logic [TW-1:0] T_HALF = TW'((DIVISOR / 2) - 1);
    localparam logic [IW-1:0] I_LAST = IW'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic [TW-1:0] timer_q;
    logic [IW-1:0] idle_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [23:0]   asm_q;
    logic [1:0]    byte_cnt_q;
    logic          wr_valid_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   wr_data_q;
    logic          byte_err_q;
    logic          overrun_q;

    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign byte_err     = byte_err_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE) || (byte_cnt_q != 2'd0);

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receive FSM, byte assembly, partial-word timeout and write-request handshake.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            idle_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            asm_q      <= 24'd0;
            byte_cnt_q <= 2'd0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'd0;
            byte_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (!enable) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            idle_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            byte_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            byte_err_q <= 1'b0;

            // Transfer is evaluated first; a word completing in the same cycle sees wr_valid_q=1 and overruns.
            if (wr_valid_q && bus.wr_ready) begin
                wr_valid_q <= 1'b0;
                wr_addr_q  <= wr_addr_q + 32'd4;
            end else begin
                wr_valid_q <= wr_valid_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_sync_q) begin
                        state_q    <= ST_START;
                        timer_q    <= T_HALF;
                        idle_cnt_q <= '0;
                    end else if (byte_cnt_q != 2'd0) begin
                        if (idle_cnt_q == I_LAST) begin
                            byte_cnt_q <= 2'd0;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IW'(1);
                        end
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (timer_q == '0) begin
                        if (!rx_sync_q) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= 3'd0;
                            timer_q   <= T_FULL;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        timer_q <= T_FULL;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ST_STOP: begin
                    if (timer_q == '0) begin
                        state_q <= ST_IDLE;
                        if (rx_sync_q) begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            case (byte_cnt_q)
                                2'd0: asm_q[7:0]   <= shift_q;
                                2'd1: asm_q[15:8]  <= shift_q;
                                2'd2: asm_q[23:16] <= shift_q;
                                2'd3: begin
                                    if (!wr_valid_q) begin
                                        wr_data_q  <= {shift_q, asm_q};
                                        wr_valid_q <= 1'b1;
                                    end else begin
                                        overrun_q  <= 1'b1;
                                    end
                                end
                                default: asm_q <= asm_q;
                            endcase
                        end else begin
                            byte_err_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_uart_word_loader.sv
// Directed bench for mfp_uart_word_loader with DIVISOR=10 and BASE_ADDR=0x100.
module tb_mfp_uart_word_loader;

    logic clk;
    logic rst_n;
    logic rx;
    logic enable;
    logic byte_err;
    logic overrun;
    logic busy;

    int          n_cmp;
    int          n_bad;
    int          xfer_cnt;
    int          err_cycles;
    logic [31:0] last_data;
    logic [31:0] last_addr;

    mfp_uart_word_loader_if bus();

    mfp_uart_word_loader #(
        .CLK_FREQ    (1_000_000),
        .BAUD        (100_000),
        .BASE_ADDR   (32'h0000_0100),
        .TIMEOUT_BITS(16)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .UART_RX (rx),
        .enable  (enable),
        .bus     (bus),
        .byte_err(byte_err),
        .overrun (overrun),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records completed transfers and byte_err cycles between clock edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_valid && bus.wr_ready) begin
                xfer_cnt  <= xfer_cnt + 1;
                last_data <= bus.wr_data;
                last_addr <= bus.wr_addr;
            end
            if (byte_err) err_cycles <= err_cycles + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = stop_bit;
        tick(10);
        rx = 1'b1;
    endtask

    task automatic clear_loader();
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.wr_valid); end
        n_cmp++; if (bus.wr_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", bus.wr_data); end
        n_cmp++; if (bus.wr_addr !== 32'h100) begin n_bad++; $display("FAIL reset_addr: got %h want 00000100", bus.wr_addr); end
        n_cmp++; if (byte_err !== 1'b0) begin n_bad++; $display("FAIL reset_byte_err: got %b want 0", byte_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_word();
        int x0;
        x0 = xfer_cnt;
        bus.wr_ready = 1'b1;
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL word_busy_partial: got %b want 1", busy); end
        send_byte(8'h12, 1'b1);
        tick(3);
        n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL word_xfer_count: got %0d want 1", xfer_cnt - x0); end
        n_cmp++; if (last_data !== 32'h12345678) begin n_bad++; $display("FAIL word_data: got %h want 12345678", last_data); end
        n_cmp++; if (last_addr !== 32'h100) begin n_bad++; $display("FAIL word_addr: got %h want 00000100", last_addr); end
        n_cmp++; if (bus.wr_addr !== 32'h104) begin n_bad++; $display("FAIL word_next_addr: got %h want 00000104", bus.wr_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL word_busy_done: got %b want 0", busy); end
    endtask

    task automatic test_stop_error();
        int x0;
        int e0;
        clear_loader();
        x0 = xfer_cnt;
        e0 = err_cycles;
        bus.wr_ready = 1'b1;
        send_byte(8'h11, 1'b1);
        send_byte(8'h55, 1'b0);
        tick(20);
        n_cmp++; if (err_cycles - e0 !== 1) begin n_bad++; $display("FAIL stoperr_pulse_cycles: got %0d want 1", err_cycles - e0); end
        n_cmp++; if (bus.wr_valid !== 1'b0) begin n_bad++; $display("FAIL stoperr_no_valid: got %b want 0", bus.wr_valid); end
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        tick(3);
        n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL stoperr_xfer_count: got %0d want 1", xfer_cnt - x0); end
        n_cmp++; if (last_data !== 32'h44332211) begin n_bad++; $display("FAIL stoperr_data: got %h want 44332211", last_data); end
        n_cmp++; if (last_addr !== 32'h100) begin n_bad++; $display("FAIL stoperr_addr: got %h want 00000100", last_addr); end
    endtask

    task automatic test_glitch();
        int x0;
        int e0;
        clear_loader();
        x0 = xfer_cnt;
        e0 = err_cycles;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_start_seen: got %b want 1", busy); end
        tick(20);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_back_idle: got %b want 0", busy); end
        n_cmp++; if (err_cycles - e0 !== 0) begin n_bad++; $display("FAIL glitch_no_err: got %0d want 0", err_cycles - e0); end
        n_cmp++; if (xfer_cnt - x0 !== 0) begin n_bad++; $display("FAIL glitch_no_xfer: got %0d want 0", xfer_cnt - x0); end
    endtask

    task automatic test_overrun();
        int x0;
        clear_loader();
        x0 = xfer_cnt;
        bus.wr_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        tick(2);
        n_cmp++; if (bus.wr_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_held: got %b want 1", bus.wr_valid); end
        n_cmp++; if (bus.wr_data !== 32'h04030201) begin n_bad++; $display("FAIL ovr_data_held: got %h want 04030201", bus.wr_data); end
        n_cmp++; if (bus.wr_addr !== 32'h100) begin n_bad++; $display("FAIL ovr_addr_held: got %h want 00000100", bus.wr_addr); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        bus.wr_ready = 1'b1;
        tick(3);
        n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL ovr_xfer_count: got %0d want 1", xfer_cnt - x0); end
        n_cmp++; if (last_data !== 32'h04030201) begin n_bad++; $display("FAIL ovr_xfer_data: got %h want 04030201", last_data); end
        n_cmp++; if (bus.wr_addr !== 32'h104) begin n_bad++; $display("FAIL ovr_next_addr: got %h want 00000104", bus.wr_addr); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        clear_loader();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_cleared: got %b want 0", overrun); end
        n_cmp++; if (bus.wr_addr !== 32'h100) begin n_bad++; $display("FAIL ovr_addr_restored: got %h want 00000100", bus.wr_addr); end
    endtask

    task automatic test_timeout();
        int x0;
        clear_loader();
        x0 = xfer_cnt;
        bus.wr_ready = 1'b1;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tmo_busy_partial: got %b want 1", busy); end
        tick(165);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_discarded: got %b want 0", busy); end
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        tick(3);
        n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL tmo_xfer_count: got %0d want 1", xfer_cnt - x0); end
        n_cmp++; if (last_data !== 32'hDDCCBBAA) begin n_bad++; $display("FAIL tmo_data: got %h want DDCCBBAA", last_data); end
        n_cmp++; if (last_addr !== 32'h100) begin n_bad++; $display("FAIL tmo_addr: got %h want 00000100", last_addr); end
    endtask

    task automatic test_async_reset();
        int x0;
        logic [7:0] b;
        clear_loader();
        bus.wr_ready = 1'b1;
        send_byte(8'h77, 1'b1);
        b = 8'h5A;
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = b[4];
        tick(5);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        n_cmp++; if (bus.wr_data !== 32'h0) begin n_bad++; $display("FAIL arst_data: got %h want 00000000", bus.wr_data); end
        n_cmp++; if (bus.wr_addr !== 32'h100) begin n_bad++; $display("FAIL arst_addr: got %h want 00000100", bus.wr_addr); end
        n_cmp++; if (bus.wr_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", bus.wr_valid); end
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        x0 = xfer_cnt;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        tick(3);
        n_cmp++; if (xfer_cnt - x0 !== 1) begin n_bad++; $display("FAIL arst_xfer_count: got %0d want 1", xfer_cnt - x0); end
        n_cmp++; if (last_data !== 32'h04030201) begin n_bad++; $display("FAIL arst_data_after: got %h want 04030201", last_data); end
        n_cmp++; if (last_addr !== 32'h100) begin n_bad++; $display("FAIL arst_addr_after: got %h want 00000100", last_addr); end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        xfer_cnt     = 0;
        err_cycles   = 0;
        last_data    = 32'h0;
        last_addr    = 32'h0;
        rst_n        = 1'b0;
        rx           = 1'b1;
        enable       = 1'b1;
        bus.wr_ready = 1'b0;
        tick(3);
        test_reset();
        rst_n = 1'b1;
        tick(3);
        test_reset();
        test_word();
        test_stop_error();
        test_glitch();
        test_overrun();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
